// File: rtl/attr_decomp_pkg.sv
// ---------------------------------------------------------------------------
// attr_decomp_pkg
//   Shared types and default parameters for the LiDAR attribute decompression
//   stages.
//
//   recon_state_e   IDLE   : between frames; only a first-of-frame beat is legal
//                   ACTIVE : inside a frame; every accepted beat is reconstructed
//   ATTR_WIDTH_DEF  default bits per attribute value / residual
//   PRED_INIT_DEF   default predictor value loaded at the start of each frame
//   MAX_POINTS_DEF  default maximum number of points in one frame
// ---------------------------------------------------------------------------
package attr_decomp_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } recon_state_e;

    localparam int ATTR_WIDTH_DEF = 8;
    localparam int PRED_INIT_DEF  = 128;
    localparam int MAX_POINTS_DEF = 4096;

endpackage : attr_decomp_pkg

// File: rtl/attr_recon_adder.sv
// ---------------------------------------------------------------------------
// attr_recon_adder
//   Combinational DPCM adder: result = f(base + sign_extend(residual)).
//   The base is an unsigned attribute value and the residual is signed.
//
//   Optional feature macro: ATTR_RECON_SAT_EN
//     defined   : result clamps to [0, 2**ATTR_WIDTH-1]
//     undefined : result wraps modulo 2**ATTR_WIDTH, which matches an encoder
//                 that produced mod-2^N residuals
//
//   Ports
//     base_i      in   ATTR_WIDTH  predictor value (unsigned)
//     residual_i  in   ATTR_WIDTH  residual (two's complement)
//     result_o    out  ATTR_WIDTH  reconstructed attribute (unsigned)
// ---------------------------------------------------------------------------
module attr_recon_adder
    import attr_decomp_pkg::*;
#(
    parameter int ATTR_WIDTH = ATTR_WIDTH_DEF
) (
    input  logic [ATTR_WIDTH-1:0] base_i,
    input  logic [ATTR_WIDTH-1:0] residual_i,
    output logic [ATTR_WIDTH-1:0] result_o
);

`ifdef ATTR_RECON_SAT_EN
    // Two guard bits hold the full range of base + residual:
    // -2**(W-1) .. 2**W-1 + 2**(W-1)-1. The top bit is the sign; the next bit
    // set on a non-negative sum means the sum exceeds the attribute range.
    logic [ATTR_WIDTH+1:0] sum;

    always_comb begin
        sum = {2'b00, base_i} + {{2{residual_i[ATTR_WIDTH-1]}}, residual_i};
        if (sum[ATTR_WIDTH+1]) begin
            result_o = '0;
        end else if (sum[ATTR_WIDTH]) begin
            result_o = '1;
        end else begin
            result_o = sum[ATTR_WIDTH-1:0];
        end
    end
`else
    // The low ATTR_WIDTH bits of the widened sum are independent of the guard
    // bits, so the wrapping variant only needs the narrow adder.
    always_comb begin
        result_o = base_i + residual_i;
    end
`endif

endmodule : attr_recon_adder

// File: rtl/attribute_reconstructor.sv
// ---------------------------------------------------------------------------
// attribute_reconstructor
//   Rebuilds absolute per-point attribute values from the signed residual
//   stream by DPCM (recon = previous recon + residual). The predictor restarts
//   at PRED_INIT on every first-of-frame beat. Output is a single registered
//   valid/ready stage carrying the point index and a frame-end marker.
//
//   Optional feature macro: ATTR_RECON_SAT_EN (saturating instead of wrapping
//   reconstruction, implemented in attr_recon_adder).
//
//   Ports
//     clk           in   1           clock
//     rst_n         in   1           asynchronous active-low reset
//     in_valid      in   1           residual beat valid
//     in_ready      out  1           stage can accept a beat
//     in_residual   in   ATTR_WIDTH  signed residual
//     in_first      in   1           beat is the first point of a frame
//     in_last       in   1           beat is the last point of a frame
//     out_valid     out  1           reconstructed beat valid
//     out_ready     in   1           downstream accepts
//     out_attr      out  ATTR_WIDTH  reconstructed unsigned attribute
//     out_idx       out  IDX_W       point index within the frame (first = 0)
//     out_last      out  1           last point of the frame
//     err_sync      out  1           sticky: beat received outside a frame
//     err_overflow  out  1           sticky: MAX_POINTS reached without in_last
//     clear_err     in   1           synchronous clear of both sticky errors
// ---------------------------------------------------------------------------
module attribute_reconstructor
    import attr_decomp_pkg::*;
#(
    parameter int ATTR_WIDTH = ATTR_WIDTH_DEF,
    parameter int PRED_INIT  = PRED_INIT_DEF,
    parameter int MAX_POINTS = MAX_POINTS_DEF,
    parameter int IDX_W      = $clog2(MAX_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ATTR_WIDTH-1:0] in_residual,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ATTR_WIDTH-1:0] out_attr,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  err_sync,
    output logic                  err_overflow,
    input  logic                  clear_err
);

    localparam logic [ATTR_WIDTH-1:0] PRED_INIT_V = ATTR_WIDTH'(PRED_INIT);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(MAX_POINTS - 1);

    recon_state_e          state_q;
    logic [ATTR_WIDTH-1:0] pred_q;
    logic [IDX_W-1:0]      cnt_q;
    logic                  out_valid_q;
    logic [ATTR_WIDTH-1:0] out_attr_q;
    logic [IDX_W-1:0]      out_idx_q;
    logic                  out_last_q;
    logic                  err_sync_q;
    logic                  err_overflow_q;

    logic                  accept;
    logic                  take;
    logic                  drop;
    logic                  overflow;
    logic                  frame_end;
    logic [ATTR_WIDTH-1:0] base;
    logic [IDX_W-1:0]      idx_d;
    logic [IDX_W-1:0]      cnt_d;
    logic [ATTR_WIDTH-1:0] attr_d;

    // A beat is reconstructed when it opens a frame or arrives inside one;
    // anything else accepted while IDLE is discarded and flagged. in_first
    // always restarts the predictor and the index, even mid-frame.
    always_comb begin
        in_ready  = !out_valid_q || out_ready;
        accept    = in_valid && in_ready;
        take      = accept && (in_first || (state_q == ACTIVE));
        drop      = accept && !take;
        base      = in_first ? PRED_INIT_V : pred_q;
        idx_d     = in_first ? '0 : cnt_q;
        cnt_d     = idx_d + IDX_W'(1);
        overflow  = take && (idx_d == LAST_IDX) && !in_last;
        frame_end = in_last || overflow;
    end

    attr_recon_adder #(
        .ATTR_WIDTH (ATTR_WIDTH)
    ) u_adder (
        .base_i     (base),
        .residual_i (in_residual),
        .result_o   (attr_d)
    );

    // Frame FSM, predictor/counter and the output register. When the output
    // is stalled nothing is accepted, so every register simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pred_q         <= PRED_INIT_V;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_attr_q     <= '0;
            out_idx_q      <= '0;
            out_last_q     <= 1'b0;
            err_sync_q     <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (take) begin
                out_valid_q <= 1'b1;
                out_attr_q  <= attr_d;
                out_idx_q   <= idx_d;
                out_last_q  <= frame_end;
                pred_q      <= attr_d;
                cnt_q       <= cnt_d;
                state_q     <= frame_end ? IDLE : ACTIVE;
            end
            // A new error in the same cycle as clear_err keeps the flag set.
            err_sync_q     <= drop || (err_sync_q && !clear_err);
            err_overflow_q <= overflow || (err_overflow_q && !clear_err);
        end
    end

    assign out_valid    = out_valid_q;
    assign out_attr     = out_attr_q;
    assign out_idx      = out_idx_q;
    assign out_last     = out_last_q;
    assign err_sync     = err_sync_q;
    assign err_overflow = err_overflow_q;

endmodule : attribute_reconstructor

// File: tb/tb_attribute_reconstructor.sv
// ---------------------------------------------------------------------------
// tb_attribute_reconstructor
//   Bench for attribute_reconstructor. The main instance (MAX_POINTS=16) is
//   followed cycle by cycle by a behavioural frame model; a second instance
//   with MAX_POINTS=4 exercises frame overflow with constant expectations.
//   Honours ATTR_RECON_SAT_EN in its expected values.
// ---------------------------------------------------------------------------
module tb_attribute_reconstructor;

    localparam int MAXP  = 16;
    localparam int MAXPS = 4;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_first, in_last, out_ready, clear_err;
    logic [7:0] in_residual;
    logic       in_ready, out_valid, out_last, err_sync, err_overflow;
    logic [7:0] out_attr;
    logic [3:0] out_idx;

    logic       vS, fS, lS, rdyS, clrS;
    logic [7:0] rS;
    logic       inRdyS, validS, lastS, errSyncS, errOvfS;
    logic [7:0] attrS;
    logic [1:0] idxS;

    int checks   = 0;
    int failures = 0;

    attribute_reconstructor #(
        .ATTR_WIDTH (8),
        .PRED_INIT  (128),
        .MAX_POINTS (MAXP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_residual  (in_residual),
        .in_first     (in_first),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_attr     (out_attr),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .err_sync     (err_sync),
        .err_overflow (err_overflow),
        .clear_err    (clear_err)
    );

    attribute_reconstructor #(
        .ATTR_WIDTH (8),
        .PRED_INIT  (128),
        .MAX_POINTS (MAXPS)
    ) dutSmall (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (vS),
        .in_ready     (inRdyS),
        .in_residual  (rS),
        .in_first     (fS),
        .in_last      (lS),
        .out_valid    (validS),
        .out_ready    (rdyS),
        .out_attr     (attrS),
        .out_idx      (idxS),
        .out_last     (lastS),
        .err_sync     (errSyncS),
        .err_overflow (errOvfS),
        .clear_err    (clrS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int sext8(input logic [7:0] r);
        return int'($signed(r));
    endfunction

    // Reconstruction rule on plain integers.
    function automatic int reconF(input int s);
`ifdef ATTR_RECON_SAT_EN
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
`else
        return ((s % 256) + 256) % 256;
`endif
    endfunction

    // Behavioural model of the main instance: frame membership, predictor,
    // point counter, one-deep output slot and the sticky error flags.
    bit mActive, mValid, mLast, mErrS, mErrO;
    int mPred, mCnt, mAttr, mIdx;

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy, acc, dropB, ovf;
        int s, idx;
        if (!rst_n) begin
            mActive <= 1'b0;
            mValid  <= 1'b0;
            mLast   <= 1'b0;
            mErrS   <= 1'b0;
            mErrO   <= 1'b0;
            mPred   <= 128;
            mCnt    <= 0;
            mAttr   <= 0;
            mIdx    <= 0;
        end else begin
            rdy   = !mValid || out_ready;
            acc   = in_valid && rdy;
            dropB = 1'b0;
            ovf   = 1'b0;
            if (mValid && out_ready) mValid <= 1'b0;
            if (acc) begin
                if (!mActive && !in_first) begin
                    dropB = 1'b1;
                end else begin
                    idx = in_first ? 0 : mCnt;
                    s   = (in_first ? 128 : mPred) + sext8(in_residual);
                    ovf = (idx == MAXP - 1) && !in_last;
                    mValid  <= 1'b1;
                    mAttr   <= reconF(s);
                    mPred   <= reconF(s);
                    mIdx    <= idx;
                    mCnt    <= idx + 1;
                    mLast   <= in_last || ovf;
                    mActive <= !(in_last || ovf);
                end
            end
            mErrS <= dropB || (mErrS && !clear_err);
            mErrO <= ovf || (mErrO && !clear_err);
        end
    end

    // Every cycle out of reset, the main instance must agree with the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("m_in_ready", in_ready, !mValid || out_ready);
            checkOutput("m_out_valid", out_valid, mValid);
            checkOutput("m_err_sync", err_sync, mErrS);
            checkOutput("m_err_overflow", err_overflow, mErrO);
            if (mValid) begin
                checkOutput("m_out_attr", out_attr, mAttr);
                checkOutput("m_out_idx", out_idx, mIdx);
                checkOutput("m_out_last", out_last, mLast);
            end
        end
    end

    // Records every attribute handed to the downstream stage.
    int xferQ[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) xferQ.push_back(int'(out_attr));
    end

    // Drives one cycle of main-instance inputs, returning 1 time unit after
    // the clock edge that consumed them.
    task automatic applyStimulus(input logic v, input logic f, input logic l,
                                 input logic [7:0] r, input logic ordy, input logic clr);
        in_valid    = v;
        in_first    = f;
        in_last     = l;
        in_residual = r;
        out_ready   = ordy;
        clear_err   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bpRes[6];
        int         expA[6];
        int         p, k, cyc;
        bit         acc;
        logic [7:0] heldAttr;
        logic [3:0] heldIdx;

        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_residual = 8'd0;
        out_ready = 1'b1; clear_err = 1'b0;
        vS = 1'b0; fS = 1'b0; lS = 1'b0; rS = 8'd0; rdyS = 1'b1; clrS = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_attr", out_attr, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_err_sync", err_sync, 0);
        checkOutput("rst_err_overflow", err_overflow, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame: +1 residuals from 128.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i == 0, i == 4, 8'd1, 1'b1, 1'b0);
            checkOutput("ramp_valid", out_valid, 1);
            checkOutput("ramp_attr", out_attr, 129 + i);
            checkOutput("ramp_idx", out_idx, i);
            checkOutput("ramp_last", out_last, i == 4);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("ramp_drained", out_valid, 0);

        // Back in IDLE: a beat without in_first is dropped and flagged.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0);
        checkOutput("sync_no_output", out_valid, 0);
        checkOutput("sync_err_set", err_sync, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        checkOutput("sync_err_cleared", err_sync, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
        checkOutput("sync_restart_attr", out_attr, 128);
        checkOutput("sync_restart_idx", out_idx, 0);
        checkOutput("sync_restart_last", out_last, 1);

        // Upper and lower range limits.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
        checkOutput("hi_first", out_attr, 255);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd127, 1'b1, 1'b0);
`ifdef ATTR_RECON_SAT_EN
        checkOutput("hi_second", out_attr, 255);
`else
        checkOutput("hi_second", out_attr, 126);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0);
        checkOutput("lo_first", out_attr, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hF6, 1'b1, 1'b0);
`ifdef ATTR_RECON_SAT_EN
        checkOutput("lo_second", out_attr, 0);
`else
        checkOutput("lo_second", out_attr, 246);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

        // Backpressure: out_ready low for three cycles mid-frame; each beat
        // is held until the stage takes it.
        p = 128;
        for (int i = 0; i < 6; i++) begin
            bpRes[i] = 8'($urandom_range(0, 255));
            p = reconF(p + sext8(bpRes[i]));
            expA[i] = p;
        end
        xferQ.delete();
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 40) begin
            logic ordy;
            ordy = !(cyc >= 2 && cyc <= 4);
            acc = !mValid || ordy;
            heldAttr = out_attr;
            heldIdx = out_idx;
            applyStimulus(1'b1, k == 0, k == 5, bpRes[k], ordy, 1'b0);
            if (!ordy) begin
                checkOutput("bp_in_ready", in_ready, 0);
                checkOutput("bp_attr_hold", out_attr, heldAttr);
                checkOutput("bp_idx_hold", out_idx, heldIdx);
            end
            if (acc) k++;
            cyc++;
        end
        checkOutput("bp_beats_sent", k, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("bp_xfer_count", xferQ.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < xferQ.size()) checkOutput("bp_seq", xferQ[i], expA[i]);
        end

        // Overflow on the MAX_POINTS=4 instance: first + 4 beats, no last.
        for (int i = 0; i < 5; i++) begin
            vS = 1'b1;
            fS = (i == 0);
            rS = 8'd2;
            @(posedge clk);
            #1;
            if (i < 4) begin
                checkOutput("ovf_valid", validS, 1);
                checkOutput("ovf_attr", attrS, 130 + 2 * i);
                checkOutput("ovf_idx", idxS, i);
                checkOutput("ovf_last", lastS, i == 3);
                checkOutput("ovf_err", errOvfS, i == 3);
            end else begin
                checkOutput("ovf_after_valid", validS, 0);
                checkOutput("ovf_after_sync", errSyncS, 1);
                checkOutput("ovf_after_in_ready", inRdyS, 1);
            end
        end
        vS = 1'b0;

        // Reset while an output is pending.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("rstmid_pending", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_valid", out_valid, 0);
        checkOutput("rstmid_small_sync", errSyncS, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
        checkOutput("rstmid_attr", out_attr, 133);
        checkOutput("rstmid_idx", out_idx, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
        checkOutput("rstmid_attr2", out_attr, 134);
        checkOutput("rstmid_idx2", out_idx, 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom % 4) != 0,
                          mActive ? (($urandom % 16) == 0) : (($urandom % 5) != 0),
                          ($urandom % 12) == 0,
                          8'($urandom),
                          ($urandom % 10) < 7,
                          ($urandom % 40) == 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_attribute_reconstructor
